sad_sequencer: RTL and testbench
================================

SAD_SEQUENCER -- requirements
Module: sad_sequencer

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 16, 32-bit words per frame row; legal range 1..65535.
REQ-002 SHALL have parameter FRAME_ROWS, default 64, frame rows; legal range 4..65535.
REQ-003 SHALL have port Clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a search; sampled only in IDLE.
REQ-006 SHALL have port win_base / frame_base  input  32 each  byte base addresses; latched on accepted start.
REQ-007 SHALL have port rd_req  output  1  read request to data memory.
REQ-008 SHALL have port rd_addr  output  32  word-aligned byte address.
REQ-009 SHALL have port rd_gnt  input  1  request accepted this cycle.
REQ-010 SHALL have port rd_valid  input  1  read data valid on the shared data bus this cycle.
REQ-011 SHALL have port window_shift / frame_shift  output  1 each  shift strobes to the SAD datapath.
REQ-012 SHALL have port min_in  output  1  SAD on datapath is a complete candidate; compare against running minimum.
REQ-013 SHALL have port min_clear  output  1  reinitialise running minimum to maximum.
REQ-014 SHALL have port load_min  output  1  select stored minimum onto SAD result.
REQ-015 SHALL have port tag  output  32  candidate position {row[15:0], col[15:0]}.
REQ-016 SHALL have port busy / done  output  1 each  search active / one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, LOAD_WIN, SCAN, FINISH.
REQ-018 IDLE: start=1 -> LOAD_WIN, latch bases, zero row/col/word counters, pulse min_clear one cycle, drop load_min.
REQ-019 At most one read outstanding; rd_req held high, rd_addr stable, until rd_gnt; no new rd_req until the cycle after the matching rd_valid.
REQ-020 LOAD_WIN: 4 reads at win_base + 4*i, i=0..3; window_shift = rd_valid for each; after 4th valid -> SCAN.
REQ-021 SCAN: per candidate (r,c), 4 reads at frame_base + 4*((r+i)*FRAME_WORDS + c), i=0..3; frame_shift = rd_valid for each.
REQ-022 min_in SHALL assert combinationally with rd_valid on the 4th word (i=3) of each candidate; tag = {r,c} that cycle.
REQ-023 Candidate order: c increments 0..FRAME_WORDS-1, then wraps to 0 with r+1; r runs 0..FRAME_ROWS-4.
REQ-024 After min_in of (FRAME_ROWS-4, FRAME_WORDS-1) -> FINISH; exactly (FRAME_ROWS-3)*FRAME_WORDS min_in pulses per search.
REQ-025 FINISH: pulse done one cycle, set load_min, -> IDLE; load_min held until next accepted start.
REQ-026 busy=1 in LOAD_WIN, SCAN, FINISH; start ignored while busy.
REQ-027 rd_valid with no read outstanding SHALL be ignored (no strobes, no state change).
REQ-028 window_shift, frame_shift, min_in SHALL never assert in the same cycle; strobes only on rd_valid.
REQ-029 tag SHALL hold last candidate value between min_in pulses.

Reset
REQ-030 Reset low SHALL asynchronously force IDLE, counters 0, bases 0, rd_req/window_shift/frame_shift/min_in/min_clear/load_min/busy/done 0, tag 0.
REQ-031 Reset mid-search SHALL abandon the outstanding read; a later rd_valid for it is ignored per REQ-027.

Configuration
REQ-032 With SAD_SEQ_PERF_EN defined: output perf_cycles (32) counts cycles from accepted start through FINISH inclusive, cleared on start, held after done, saturating at 32'hFFFFFFFF.
REQ-033 Without SAD_SEQ_PERF_EN: port perf_cycles and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-034 FRAME_WORDS=1, FRAME_ROWS=4, win_base=0x100, frame_base=0x200, gnt/valid 1 cycle each -> reads 0x100..0x10C then 0x200..0x20C, one min_in with tag 0, done, load_min=1.
REQ-035 Defaults, frame_base=0 -> 976 min_in pulses; last tag 0x003C000F; 4th read of last candidate at 0x00000FFC.
REQ-036 rd_gnt withheld 5 cycles -> rd_req/rd_addr stable throughout; no strobes until rd_valid.
REQ-037 Spurious rd_valid in IDLE, and start pulsed during SCAN -> no strobes, no restart, min_in count unchanged.
REQ-038 Reset low during SCAN then new start -> all outputs 0 during reset; second search complete and correct.
REQ-039 SAD_SEQ_PERF_EN, FRAME_WORDS=1, FRAME_ROWS=4, gnt/valid each 1 cycle after prior -> perf_cycles equals bench-counted start-to-done cycles, stable after done.

Source files
------------

// File: rtl/sad_sequencer.sv
// sad_sequencer: read/strobe sequencer for a 4-word window block search.
// Define SAD_SEQ_PERF_EN to add the perf_cycles busy-cycle counter port.
module sad_sequencer #(
    parameter int unsigned FRAME_WORDS = 16,
    parameter int unsigned FRAME_ROWS  = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [31:0] win_base,
    input  logic [31:0] frame_base,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_gnt,
    input  logic        rd_valid,
    output logic        window_shift,
    output logic        frame_shift,
    output logic        min_in,
    output logic        min_clear,
    output logic        load_min,
    output logic [31:0] tag,
    output logic        busy,
    output logic        done
`ifdef SAD_SEQ_PERF_EN
    ,
    output logic [31:0] perf_cycles
`endif
);

    localparam logic [15:0] LAST_ROW = 16'(FRAME_ROWS - 4);
    localparam logic [15:0] LAST_COL = 16'(FRAME_WORDS - 1);
    localparam logic [31:0] FW32     = 32'(FRAME_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WIN,
        SCAN,
        FINISH
    } state_t;

    state_t state, state_nxt;

    logic [31:0] win_q;
    logic [31:0] frame_q;
    logic        req_q;
    logic        outst_q;
    logic [1:0]  idx_q;
    logic [15:0] row_q;
    logic [15:0] col_q;
    logic [31:0] cand_q;
    logic [31:0] ptr_q;
    logic [31:0] addr_q;
    logic [31:0] tag_q;
    logic        load_min_q;
    logic        min_clear_q;

    logic        accept;
    logic        beat;
    logic        last_word;
    logic        last_cand;
    logic [1:0]  idx_nxt;
    logic [31:0] ptr_step;
    logic [31:0] cand_nxt;

    assign accept    = (state == IDLE) && start;
    // Only a response to our own granted read counts as a beat.
    assign beat      = outst_q && rd_valid;
    assign last_word = (idx_q == 2'd3);
    assign last_cand = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign idx_nxt   = idx_q + 2'd1;
    assign ptr_step  = ptr_q + FW32;
    assign cand_nxt  = cand_q + 32'd1;

    assign rd_req    = req_q;
    assign rd_addr   = addr_q;
    assign load_min  = load_min_q;
    assign min_clear = min_clear_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        window_shift = 1'b0;
        frame_shift  = 1'b0;
        min_in       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LOAD_WIN;
            end
            LOAD_WIN: begin
                busy         = 1'b1;
                window_shift = beat;
                if (beat && last_word) state_nxt = SCAN;
            end
            SCAN: begin
                busy        = 1'b1;
                frame_shift = beat && !last_word;
                min_in      = beat && last_word;
                if (min_in && last_cand) state_nxt = FINISH;
            end
            FINISH: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        tag = min_in ? {row_q, col_q} : tag_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            win_q       <= '0;
            frame_q     <= '0;
            req_q       <= 1'b0;
            outst_q     <= 1'b0;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cand_q      <= '0;
            ptr_q       <= '0;
            addr_q      <= '0;
            tag_q       <= '0;
            load_min_q  <= 1'b0;
            min_clear_q <= 1'b0;
        end else begin
            min_clear_q <= 1'b0;
            if (state == FINISH) load_min_q <= 1'b1;
            if (accept) begin
                win_q       <= win_base;
                frame_q     <= frame_base;
                idx_q       <= '0;
                row_q       <= '0;
                col_q       <= '0;
                cand_q      <= '0;
                ptr_q       <= '0;
                req_q       <= 1'b1;
                outst_q     <= 1'b0;
                addr_q      <= win_base;
                min_clear_q <= 1'b1;
                load_min_q  <= 1'b0;
            end else begin
                if (req_q && rd_gnt) begin
                    req_q   <= 1'b0;
                    outst_q <= 1'b1;
                end
                if (beat) begin
                    outst_q <= 1'b0;
                    idx_q   <= idx_nxt;
                    unique case (1'b1)
                        (state == LOAD_WIN) && !last_word: begin
                            req_q  <= 1'b1;
                            addr_q <= win_q + {28'd0, idx_nxt, 2'b00};
                        end
                        (state == LOAD_WIN) && last_word: begin
                            req_q  <= 1'b1;
                            ptr_q  <= '0;
                            addr_q <= frame_q;
                        end
                        (state == SCAN) && !last_word: begin
                            req_q  <= 1'b1;
                            ptr_q  <= ptr_step;
                            addr_q <= frame_q + {ptr_step[29:0], 2'b00};
                        end
                        (state == SCAN) && last_word: begin
                            tag_q <= {row_q, col_q};
                            // Candidates are linear in row-major word order.
                            if (!last_cand) begin
                                req_q  <= 1'b1;
                                cand_q <= cand_nxt;
                                ptr_q  <= cand_nxt;
                                addr_q <= frame_q + {cand_nxt[29:0], 2'b00};
                                if (col_q == LAST_COL) begin
                                    col_q <= '0;
                                    row_q <= row_q + 16'd1;
                                end else begin
                                    col_q <= col_q + 16'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef SAD_SEQ_PERF_EN
    logic [31:0] perf_q;

    // Start cycle counts as 1; every busy cycle after it adds one.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= 32'd1;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_sad_sequencer.sv
// tb_sad_sequencer: directed bench with a read/strobe expectation model.
// Define SAD_SEQ_PERF_EN to also check perf_cycles.
`timescale 1ns/1ps
module tb_sad_sequencer;

    localparam int FW = 16;
    localparam int FR = 64;
    localparam int NCAND = FW * (FR - 3);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Main instance, default geometry
    logic        start = 0;
    logic [31:0] win_base = 0;
    logic [31:0] frame_base = 0;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        resp_gnt;
    logic        resp_valid;
    logic        spur_valid = 0;
    logic        rd_valid;
    logic        ws, fs, mi, mc, lm, busy, done;
    logic [31:0] tag;
    assign rd_valid = resp_valid | spur_valid;
`ifdef SAD_SEQ_PERF_EN
    logic [31:0] perf;
`endif

    sad_sequencer #(.FRAME_WORDS(FW), .FRAME_ROWS(FR)) dut (
        .Clk(clk), .Reset(rst_n), .start(start),
        .win_base(win_base), .frame_base(frame_base),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(resp_gnt), .rd_valid(rd_valid),
        .window_shift(ws), .frame_shift(fs), .min_in(mi),
        .min_clear(mc), .load_min(lm), .tag(tag),
        .busy(busy), .done(done)
`ifdef SAD_SEQ_PERF_EN
        , .perf_cycles(perf)
`endif
    );

    // Small instance, 1 word x 4 rows
    logic        s_start = 0;
    logic [31:0] s_win = 0;
    logic [31:0] s_frame = 0;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_gnt = 0;
    logic        s_valid = 0;
    logic        s_ws, s_fs, s_mi, s_mc, s_lm, s_busy, s_done;
    logic [31:0] s_tag;
`ifdef SAD_SEQ_PERF_EN
    logic [31:0] s_perf;
`endif

    sad_sequencer #(.FRAME_WORDS(1), .FRAME_ROWS(4)) dut_s (
        .Clk(clk), .Reset(rst_n), .start(s_start),
        .win_base(s_win), .frame_base(s_frame),
        .rd_req(s_req), .rd_addr(s_addr),
        .rd_gnt(s_gnt), .rd_valid(s_valid),
        .window_shift(s_ws), .frame_shift(s_fs), .min_in(s_mi),
        .min_clear(s_mc), .load_min(s_lm), .tag(s_tag),
        .busy(s_busy), .done(s_done)
`ifdef SAD_SEQ_PERF_EN
        , .perf_cycles(s_perf)
`endif
    );

    // Memory responder for the main instance
    int gnt_dly = 0;
    int val_dly = 0;

    initial begin : responder
        int ph;
        int cnt;
        ph = 0;
        cnt = 0;
        resp_gnt = 0;
        resp_valid = 0;
        forever begin
            @(posedge clk);
            #1;
            resp_gnt = 0;
            resp_valid = 0;
            if (!rst_n) begin
                ph = 0;
                cnt = 0;
            end else if (ph == 0) begin
                if (rd_req) begin
                    if (cnt >= gnt_dly) begin
                        resp_gnt = 1;
                        ph = 1;
                        cnt = 0;
                    end else cnt++;
                end
            end else begin
                if (cnt >= val_dly) begin
                    resp_valid = 1;
                    ph = 0;
                    cnt = 0;
                end else cnt++;
            end
        end
    end

    // Expected read stream of one search
    typedef struct {
        logic [31:0] addr;
        int          kind;
        logic [31:0] tag;
    } exp_t;

    exp_t exp_q[$];

    task automatic build_exp(input logic [31:0] wb, input logic [31:0] fb);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            e.addr = wb + 32'(4 * i);
            e.kind = 0;
            e.tag  = 0;
            exp_q.push_back(e);
        end
        for (int r = 0; r <= FR - 4; r++)
            for (int c = 0; c < FW; c++)
                for (int i = 0; i < 4; i++) begin
                    e.addr = fb + 32'(4 * ((r + i) * FW + c));
                    e.kind = (i == 3) ? 2 : 1;
                    e.tag  = {16'(r), 16'(c)};
                    exp_q.push_back(e);
                end
    endtask

    bit          m_busy, m_lm, m_out, req_lat;
    bit          prev_acc, pend_done, exp_done;
    logic [31:0] m_tag, req_addr, last_gnt_addr;
    int          dut_min = 0;

    always @(negedge clk) begin : cmp
        exp_t e;
        logic [2:0] exp_str;
        if (!rst_n) begin
            chk("rst_ctl", {24'd0, rd_req, ws, fs, mi, mc, lm, busy, done}, 0);
            chk("rst_tag", tag, 0);
            chk("rst_addr", rd_addr, 0);
            m_busy = 0; m_lm = 0; m_out = 0; req_lat = 0;
            prev_acc = 0; pend_done = 0; m_tag = 0;
            exp_q.delete();
        end else begin
            exp_done = pend_done;
            pend_done = 0;
            if (prev_acc) begin m_busy = 1; m_lm = 0; end
            chk("min_clear", {31'd0, mc}, {31'd0, prev_acc});
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("load_min", {31'd0, lm}, {31'd0, m_lm});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            if (rd_req) begin
                chk("req_one_outst", {31'd0, m_out}, 0);
                if (!req_lat) begin
                    chk("rd_addr", rd_addr,
                        exp_q.size() > 0 ? exp_q[0].addr : 32'hDEAD_BEEF);
                    req_lat = 1;
                    req_addr = rd_addr;
                end else chk("rd_addr_stable", rd_addr, req_addr);
            end
            if (rd_valid && m_out) begin
                m_out = 0;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", {29'd0, ws, fs, mi}, 0);
                end else begin
                    e = exp_q.pop_front();
                    exp_str = (e.kind == 0) ? 3'b100 :
                              (e.kind == 1) ? 3'b010 : 3'b001;
                    chk("strobes", {29'd0, ws, fs, mi}, {29'd0, exp_str});
                    if (e.kind == 2) begin
                        m_tag = e.tag;
                        if (exp_q.size() == 0) pend_done = 1;
                    end
                end
            end else begin
                chk("no_strobe", {29'd0, ws, fs, mi}, 0);
            end
            chk("tag", tag, m_tag);
            if (mi) dut_min++;
            if (rd_req && resp_gnt) begin
                m_out = 1;
                req_lat = 0;
                last_gnt_addr = rd_addr;
            end
            if (exp_done) begin m_busy = 0; m_lm = 1; end
            prev_acc = start && !m_busy;
            if (prev_acc) build_exp(win_base, frame_base);
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        chk(name, {31'd0, seen}, 1);
    endtask

    task automatic wait_min(input int target, input int budget);
        for (int k = 0; k < budget && dut_min < target; k++)
            @(negedge clk);
        chk("wait_min", {31'd0, dut_min >= target}, 1);
    endtask

    task automatic run_small();
        logic [31:0] addrs[$];
        logic [31:0] ref_a [8];
        int  ph, ncyc, nws, nfs, nmi, nmc;
        bit  sdone;
        logic [31:0] stag;
        ref_a = '{32'h100, 32'h104, 32'h108, 32'h10C,
                  32'h200, 32'h204, 32'h208, 32'h20C};
        ph = 0; ncyc = 0; nws = 0; nfs = 0; nmi = 0; nmc = 0;
        sdone = 0; stag = 32'hFFFF_FFFF;
        s_win = 32'h100;
        s_frame = 32'h200;
        @(posedge clk); #1 s_start = 1;
        for (int k = 0; k < 200 && !sdone; k++) begin
            @(negedge clk);
            ncyc++;
            if (ph == 0 && s_req) begin
                addrs.push_back(s_addr);
                ph = 1;
            end
            if (s_ws) nws++;
            if (s_fs) nfs++;
            if (s_mc) nmc++;
            if (s_mi) begin nmi++; stag = s_tag; end
            if (s_done) sdone = 1;
            @(posedge clk); #1;
            s_start = 0; s_gnt = 0; s_valid = 0;
            if (ph == 1) begin s_gnt = 1; ph = 2; end
            else if (ph == 2) begin s_valid = 1; ph = 0; end
        end
        chk("s_done", {31'd0, sdone}, 1);
        chk("s_nreads", addrs.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("s_addr%0d", i),
                i < addrs.size() ? addrs[i] : 32'hX, ref_a[i]);
        chk("s_ws_cnt", nws, 4);
        chk("s_fs_cnt", nfs, 3);
        chk("s_min_cnt", nmi, 1);
        chk("s_min_clear_cnt", nmc, 1);
        chk("s_tag", stag, 0);
        @(negedge clk);
        chk("s_load_min", {31'd0, s_lm}, 1);
        chk("s_busy_end", {31'd0, s_busy}, 0);
`ifdef SAD_SEQ_PERF_EN
        chk("s_perf", s_perf, ncyc);
        repeat (3) @(negedge clk);
        chk("s_perf_hold", s_perf, ncyc);
`endif
    endtask

    initial begin : main
        int base;
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        @(negedge clk);
        chk("lit_rst_tag", tag, 0);
        chk("lit_rst_lm", {31'd0, lm}, 0);

        run_small();

        // Full default search, zero-wait memory
        win_base = 32'h1000;
        frame_base = 32'h0;
        pulse_start();
        wait_done("a_done", 20000);
        @(negedge clk);
        chk("a_mins", dut_min, NCAND);
        chk("a_last_tag", tag, 32'h003C_000F);
        chk("a_last_addr", last_gnt_addr, 32'h0000_0FFC);
        chk("a_load_min", {31'd0, lm}, 1);

        // Stray response while idle
        @(posedge clk); #1 spur_valid = 1;
        @(posedge clk); #1 spur_valid = 0;
        repeat (2) @(negedge clk);
        chk("spur_mins", dut_min, NCAND);
        chk("spur_busy", {31'd0, busy}, 0);

        // Slow grants, then a start pulse mid-scan
        gnt_dly = 5;
        val_dly = 2;
        win_base = 32'h40;
        frame_base = 32'h8000;
        pulse_start();
        wait_min(NCAND + 10, 2000);
        pulse_start();
        gnt_dly = 0;
        val_dly = 1;
        wait_done("b_done", 30000);
        @(negedge clk);
        chk("b_mins", dut_min, 2 * NCAND);
        chk("b_last_addr", last_gnt_addr, 32'h0000_8FFC);

        // Reset in the middle of a scan, then a clean search
        val_dly = 0;
        win_base = 32'h0;
        frame_base = 32'h2000;
        pulse_start();
        wait_min(2 * NCAND + 50, 2000);
        for (int k = 0; k < 20 && !m_out; k++) @(negedge clk);
        chk("c_outstanding", {31'd0, m_out}, 1);
        @(posedge clk); #3 rst_n = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1 spur_valid = 1;
        @(posedge clk); #1 spur_valid = 0;
        base = dut_min;
        win_base = 32'h300;
        pulse_start();
        wait_done("c_done", 20000);
        @(negedge clk);
        chk("c_mins", dut_min - base, NCAND);
        chk("c_last_tag", tag, 32'h003C_000F);
        chk("c_last_addr", last_gnt_addr, 32'h0000_2FFC);
        chk("c_load_min", {31'd0, lm}, 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
